// File: rtl/fdc_pkg.sv
// Shared types for the floppy-controller SD block arbiter.
// Arbiter state encoding, drive index type, transfer direction.
package fdc_pkg;

    localparam int FDC_NDRIVES = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER,
        DONE
    } arb_state_t;

    typedef logic [1:0] drv_idx_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } op_t;

endpackage

// File: rtl/fdc_rr_picker.sv
// Combinational round-robin selector for the SD arbiter.
// Ports: req   - per-drive request vector
//        ptr   - last granted drive; search starts at ptr+1
//        valid - some drive is requesting
//        idx   - first requester at/after ptr+1 (wrapping)
module fdc_rr_picker
    import fdc_pkg::*;
#(
    parameter int NDRIVES = FDC_NDRIVES
) (
    input  logic [NDRIVES-1:0] req,
    input  drv_idx_t           ptr,
    output logic               valid,
    output drv_idx_t           idx
);

    always_comb begin
        valid = 1'b0;
        idx   = ptr;
        // k runs 1..NDRIVES so the last drive examined is ptr
        // itself: a lone requester is still served.
        for (int k = 1; k <= NDRIVES; k++) begin
            drv_idx_t c;
            c = drv_idx_t'((int'(ptr) + k) % NDRIVES);
            if (!valid && req[c]) begin
                valid = 1'b1;
                idx   = c;
            end
        end
    end

endmodule

// File: rtl/fdc_sd_arbiter.sv
// Funnels the per-drive SD block request ports onto one host port.
// One transfer at a time, strict round-robin between drives.
// Ports: CLK, RESET (sync, active high)
//        drv_lba/drv_rd/drv_wr/drv_buff_din - per-drive requests
//        drv_ack      - per-drive ack, only the granted bit toggles
//        sd_lba/sd_rd/sd_wr - registered host request
//        sd_ack       - host ack, high for a whole block
//        sd_buff_din  - write data of the granted drive
//        grant_idx, busy, timeout_err - status
// Build option: define FDC_ARB_WATCHDOG_EN to add a REQ/XFER
// watchdog that aborts a stuck transfer and pulses timeout_err.
module fdc_sd_arbiter
    import fdc_pkg::*;
#(
    parameter int NDRIVES   = FDC_NDRIVES,
    parameter int LBA_W     = 32,
    parameter int TIMEOUT_W = 24
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [NDRIVES-1:0][LBA_W-1:0] drv_lba,
    input  logic [NDRIVES-1:0]            drv_rd,
    input  logic [NDRIVES-1:0]            drv_wr,
    input  logic [NDRIVES-1:0][7:0]       drv_buff_din,
    output logic [NDRIVES-1:0]            drv_ack,
    output logic [LBA_W-1:0]              sd_lba,
    output logic                          sd_rd,
    output logic                          sd_wr,
    input  logic                          sd_ack,
    output logic [7:0]                    sd_buff_din,
    output logic [1:0]                    grant_idx,
    output logic                          busy,
    output logic                          timeout_err
);

    arb_state_t          state_q, state_d;
    drv_idx_t            grant_q, grant_d;
    drv_idx_t            ptr_q, ptr_d;
    logic [LBA_W-1:0]    lba_q, lba_d;
    logic                sd_rd_q, sd_rd_d;
    logic                sd_wr_q, sd_wr_d;
    logic [NDRIVES-1:0]  ack_q, ack_d;
    logic                busy_q, busy_d;
    logic                tmo_q, tmo_d;

    logic [NDRIVES-1:0]  req;
    logic                pick_vld;
    drv_idx_t            pick_idx;
    logic [NDRIVES-1:0]  grant_oh;
    op_t                 op;

    assign req = drv_rd | drv_wr;

    fdc_rr_picker #(
        .NDRIVES (NDRIVES)
    ) u_picker (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    always_comb begin
        grant_oh          = '0;
        grant_oh[grant_q] = 1'b1;
    end

`ifdef FDC_ARB_WATCHDOG_EN
    logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
    logic [TIMEOUT_W-1:0] wdog_inc;
    assign wdog_inc = wdog_q + 1'b1;
`else
    // TIMEOUT_W only sizes the watchdog, which this build omits.
    if (TIMEOUT_W < 1) begin : g_no_watchdog_width
    end
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        lba_d   = lba_q;
        sd_rd_d = sd_rd_q;
        sd_wr_d = sd_wr_q;
        ack_d   = '0;
        tmo_d   = 1'b0;
        op      = OP_RD;

        unique case (state_q)
            IDLE: begin
                // A host ack still high from before a reset
                // must drain before a new request goes out.
                if (pick_vld && !sd_ack) begin
                    op      = drv_rd[pick_idx] ? OP_RD : OP_WR;
                    grant_d = pick_idx;
                    lba_d   = drv_lba[pick_idx];
                    sd_rd_d = (op == OP_RD);
                    sd_wr_d = (op == OP_WR);
                    state_d = REQ;
                end
            end
            REQ: begin
                if (sd_ack) begin
                    sd_rd_d = 1'b0;
                    sd_wr_d = 1'b0;
                    ack_d   = grant_oh;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (sd_ack) begin
                    ack_d = grant_oh;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ptr_d   = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef FDC_ARB_WATCHDOG_EN
        wdog_d = '0;
        if (state_q == REQ || state_q == XFER) begin
            wdog_d = wdog_inc;
            if (&wdog_inc) begin
                sd_rd_d = 1'b0;
                sd_wr_d = 1'b0;
                ack_d   = '0;
                tmo_d   = 1'b1;
                state_d = DONE;
            end
        end
`endif

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            lba_q   <= '0;
            sd_rd_q <= 1'b0;
            sd_wr_q <= 1'b0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            lba_q   <= lba_d;
            sd_rd_q <= sd_rd_d;
            sd_wr_q <= sd_wr_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
        end
    end

`ifdef FDC_ARB_WATCHDOG_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
    assign timeout_err = tmo_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign drv_ack     = ack_q;
    assign sd_lba      = lba_q;
    assign sd_rd       = sd_rd_q;
    assign sd_wr       = sd_wr_q;
    assign sd_buff_din = drv_buff_din[grant_q];
    assign grant_idx   = grant_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_fdc_sd_arbiter.sv
// Directed bench for fdc_sd_arbiter.
// Inputs change and outputs are sampled on the falling edge.
module tb_fdc_sd_arbiter;
    import fdc_pkg::*;

    localparam int N  = 4;
    localparam int LW = 32;
`ifdef FDC_ARB_WATCHDOG_EN
    localparam int TW = 4;
`else
    localparam int TW = 24;
`endif

    logic                  CLK = 1'b0;
    logic                  RESET;
    logic [N-1:0][LW-1:0]  drv_lba;
    logic [N-1:0]          drv_rd;
    logic [N-1:0]          drv_wr;
    logic [N-1:0][7:0]     drv_buff_din;
    logic [N-1:0]          drv_ack;
    logic [LW-1:0]         sd_lba;
    logic                  sd_rd;
    logic                  sd_wr;
    logic                  sd_ack;
    logic [7:0]            sd_buff_din;
    logic [1:0]            grant_idx;
    logic                  busy;
    logic                  timeout_err;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    fdc_sd_arbiter #(
        .NDRIVES   (N),
        .LBA_W     (LW),
        .TIMEOUT_W (TW)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .drv_lba      (drv_lba),
        .drv_rd       (drv_rd),
        .drv_wr       (drv_wr),
        .drv_buff_din (drv_buff_din),
        .drv_ack      (drv_ack),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_din  (sd_buff_din),
        .grant_idx    (grant_idx),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset();
        RESET  = 1'b1;
        drv_rd = '0;
        drv_wr = '0;
        sd_ack = 1'b0;
        tick(2);
        RESET  = 1'b0;
    endtask

    initial begin
        int errs;
        int cnt;
        RESET        = 1'b1;
        drv_lba      = '0;
        drv_rd       = '0;
        drv_wr       = '0;
        drv_buff_din = '0;
        sd_ack       = 1'b0;
        do_reset();

        // reset values
        check("rst_busy", busy, 1'b0);
        check("rst_rd", sd_rd, 1'b0);
        check("rst_wr", sd_wr, 1'b0);
        check("rst_lba", sd_lba, 32'h0);
        check("rst_ack", drv_ack, 4'h0);
        check("rst_gnt", grant_idx, 2'd0);
        check("rst_tmo", timeout_err, 1'b0);

        // 1: single read on drive 1
        drv_lba[1] = 32'h25;
        drv_rd[1]  = 1'b1;
        tick();
        check("t1_rd", sd_rd, 1'b1);
        check("t1_wr", sd_wr, 1'b0);
        check("t1_lba", sd_lba, 32'h25);
        check("t1_gnt", grant_idx, 2'd1);
        check("t1_busy", busy, 1'b1);
        check("t1_noack", drv_ack, 4'h0);
        tick(3);
        check("t1_hold_rd", sd_rd, 1'b1);
        check("t1_hold_lba", sd_lba, 32'h25);
        sd_ack = 1'b1;
        tick();
        check("t1_ack", drv_ack, 4'b0010);
        check("t1_rdclr", sd_rd, 1'b0);
        errs = 0;
        repeat (511) begin
            tick();
            if (drv_ack !== 4'b0010) errs++;
        end
        check("t1_ack_hold", errs, 0);
        sd_ack    = 1'b0;
        drv_rd[1] = 1'b0;
        tick();
        check("t1_ack_drop", drv_ack, 4'h0);
        check("t1_done_busy", busy, 1'b1);
        tick();
        check("t1_idle", busy, 1'b0);

        // 2: contention drive 0 read + drive 2 write, ptr 0
        do_reset();
        drv_rd[0] = 1'b1;
        drv_wr[2] = 1'b1;
        tick();
        check("t2_gnt_a", grant_idx, 2'd2);
        check("t2_wr_a", sd_wr, 1'b1);
        check("t2_rd_a", sd_rd, 1'b0);
        sd_ack = 1'b1;
        tick();
        check("t2_ack_a", drv_ack, 4'b0100);
        tick(4);
        sd_ack    = 1'b0;
        drv_wr[2] = 1'b0;
        tick(2);
        check("t2_gap", busy, 1'b0);
        tick();
        check("t2_gnt_b", grant_idx, 2'd0);
        check("t2_rd_b", sd_rd, 1'b1);
        check("t2_wr_b", sd_wr, 1'b0);
        sd_ack = 1'b1;
        tick();
        check("t2_ack_b", drv_ack, 4'b0001);
        sd_ack    = 1'b0;
        drv_rd[0] = 1'b0;
        tick(2);
        check("t2_end", busy, 1'b0);

        // 3: write-data mux on drive 3
        do_reset();
        drv_buff_din    = '0;
        drv_buff_din[3] = 8'hA5;
        drv_lba[3]      = 32'h1234;
        drv_wr[3]       = 1'b1;
        tick();
        check("t3_gnt", grant_idx, 2'd3);
        check("t3_wr", sd_wr, 1'b1);
        sd_ack = 1'b1;
        tick();
        check("t3_ack", drv_ack, 4'b1000);
        check("t3_din_a", sd_buff_din, 8'hA5);
        tick(10);
        check("t3_din_b", sd_buff_din, 8'hA5);
        drv_buff_din[3] = 8'h3C;
        drv_buff_din[0] = 8'hFF;
        #1;
        check("t3_din_c", sd_buff_din, 8'h3C);
        sd_ack    = 1'b0;
        drv_wr[3] = 1'b0;
        tick(2);
        check("t3_end", busy, 1'b0);

        // 4: reset mid-transfer with host ack high
        do_reset();
        drv_lba[1] = 32'h77;
        drv_rd[1]  = 1'b1;
        tick();
        sd_ack = 1'b1;
        tick();
        check("t4_xfer", drv_ack, 4'b0010);
        drv_rd[0] = 1'b1;
        RESET     = 1'b1;
        tick();
        check("t4_busy", busy, 1'b0);
        check("t4_ack", drv_ack, 4'h0);
        check("t4_rd", sd_rd, 1'b0);
        check("t4_lba", sd_lba, 32'h0);
        check("t4_gnt", grant_idx, 2'd0);
        RESET     = 1'b0;
        drv_rd[1] = 1'b0;
        tick(3);
        check("t4_stale_busy", busy, 1'b0);
        check("t4_stale_rd", sd_rd, 1'b0);
        sd_ack = 1'b0;
        tick();
        check("t4_regrant_rd", sd_rd, 1'b1);
        check("t4_regrant_gnt", grant_idx, 2'd0);
        sd_ack = 1'b1;
        tick();
        sd_ack    = 1'b0;
        drv_rd[0] = 1'b0;
        tick(2);

        // 5: read and write both on drive 0 -> read
        do_reset();
        drv_lba[0] = 32'hDEADBEEF;
        drv_rd[0]  = 1'b1;
        drv_wr[0]  = 1'b1;
        tick();
        check("t5_rd", sd_rd, 1'b1);
        check("t5_wr", sd_wr, 1'b0);
        check("t5_lba", sd_lba, 32'hDEADBEEF);
        sd_ack = 1'b1;
        tick();
        sd_ack    = 1'b0;
        drv_rd[0] = 1'b0;
        drv_wr[0] = 1'b0;
        tick(2);
        check("t5_end", busy, 1'b0);

`ifdef FDC_ARB_WATCHDOG_EN
        // 6: watchdog abort with no host ack
        do_reset();
        drv_rd[2] = 1'b1;
        tick();
        cnt = 0;
        while (sd_rd && cnt < 100) begin
            cnt++;
            tick();
        end
        drv_rd[2] = 1'b0;
        check("t6_cycles", cnt, 15);
        check("t6_tmo", timeout_err, 1'b1);
        check("t6_busy_a", busy, 1'b1);
        tick();
        check("t6_tmo_pulse", timeout_err, 1'b0);
        check("t6_busy_b", busy, 1'b0);
`else
        // 6: no watchdog -> REQ waits for the host
        do_reset();
        drv_rd[2] = 1'b1;
        cnt = 0;
        repeat (40) begin
            tick();
            if (sd_rd !== 1'b1 || timeout_err !== 1'b0) cnt++;
        end
        check("t6_wait", cnt, 0);
        sd_ack = 1'b1;
        tick();
        sd_ack    = 1'b0;
        drv_rd[2] = 1'b0;
        tick(2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
